aes_key_expand_seq: RTL and testbench

//  Iterative AES key schedule for AES-128/192/256, selected per request. Computes one 32-bit word per cycle

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_key_expand_seq_if.sv | 16 +
 rtl/aes_sub_word.sv | 9 +
 rtl/aes_key_expand_seq.sv | 107 ++++++++++
 tb/tb_aes_key_expand_seq.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: key-length/FSM enums, S-box table, xtime and Nk/Nr/Nw lookups for the AES key schedule
package aes_pkg;
  typedef enum logic [1:0] {KL_128 = 2'd0, KL_192 = 2'd1, KL_256 = 2'd2} key_len_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_READY} state_e;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    return kl == KL_128 ? 4'd4 : kl == KL_192 ? 4'd6 : kl == KL_256 ? 4'd8 : 4'd0;
  endfunction
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return nk_of(kl) == 4'd0 ? 4'd0 : nk_of(kl) + 4'd6;
  endfunction
  function automatic logic [5:0] nw_of(input logic [1:0] kl);
    return {nr_of(kl) + 4'd1, 2'b00};
  endfunction
endpackage

// File: rtl/aes_key_expand_seq_if.sv
// aes_key_expand_seq_if: key-load request and round-key read port of the key schedule
interface aes_key_expand_seq_if;
  logic         start_valid;
  logic         start_ready;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         keys_valid;
  logic         key_err;
  logic [3:0]   nr;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  modport master (output start_valid, key_len, key, rk_rd_idx,
                  input start_ready, keys_valid, key_err, nr, rk_rd_data);
  modport slave (input start_valid, key_len, key, rk_rd_idx,
                 output start_ready, keys_valid, key_err, nr, rk_rd_data);
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational 32-bit SubWord, four S-box lookups
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);
  assign y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: iterative AES-128/192/256 key schedule, one word per cycle; optional AES_KEY_EXPAND_ZEROIZE_EN adds zeroize
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input logic clk,
  input logic rst_n,
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
  input logic zeroize,
`endif
  aes_key_expand_seq_if.slave bus
);
  localparam int NW_MAX = 4 * (MAX_KEY_BITS / 32 + 7);
  localparam logic [8:0] MAX_B = 9'(MAX_KEY_BITS);
  state_e      state;
  logic [31:0] w [NW_MAX];
  logic [5:0]  i;
  logic [2:0]  ph;
  logic [3:0]  nk;
  logic [1:0]  kl_q;
  logic [7:0]  rcon;
  logic        keys_valid, key_err;
  logic [3:0]  nr;
  logic [3:0]  nk_in, r;
  logic        legal, acc, start_ready;
  logic [31:0] t, wp, rot, sub_in, sw, w_new;
  logic [5:0]  base;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
  assign start_ready = state != ST_EXPAND && !zeroize;
`else
  assign start_ready = state != ST_EXPAND;
`endif
  assign nk_in = nk_of(bus.key_len);
  assign legal = bus.key_len != 2'd3 && {nk_in, 5'd0} <= MAX_B;
  assign acc = bus.start_valid && start_ready;
  // ph tracks i mod Nk, so ph==0 is the RotWord/Rcon step and ph==4 the extra AES-256 SubWord step
  assign t = w[i - 6'd1];
  assign wp = w[i - {2'b00, nk}];
  assign rot = {t[23:0], t[31:24]};
  assign sub_in = ph == 3'd0 ? rot : t;
  aes_sub_word u_sub_word (.a(sub_in), .y(sw));
  assign w_new = ph == 3'd0 ? wp ^ sw ^ {rcon, 24'h0} :
                 (nk == 4'd8 && ph == 3'd4) ? wp ^ sw : wp ^ t;
  assign r = bus.rk_rd_idx > nr ? 4'd0 : bus.rk_rd_idx;
  assign base = {r, 2'b00};
  assign bus.rk_rd_data = (keys_valid && bus.rk_rd_idx <= nr) ?
                          {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : 128'h0;
  assign bus.start_ready = start_ready;
  assign bus.keys_valid = keys_valid;
  assign bus.key_err = key_err;
  assign bus.nr = nr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      for (int k = 0; k < NW_MAX; k++) w[k] <= '0;
      i <= '0;
      ph <= '0;
      nk <= '0;
      kl_q <= '0;
      rcon <= '0;
      keys_valid <= 1'b0;
      key_err <= 1'b0;
      nr <= '0;
    end else begin
      key_err <= 1'b0;
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
      if (zeroize) begin
        state <= ST_IDLE;
        for (int k = 0; k < NW_MAX; k++) w[k] <= '0;
        i <= '0;
        ph <= '0;
        rcon <= '0;
        keys_valid <= 1'b0;
        nr <= '0;
      end else
`endif
      if (acc) begin
        keys_valid <= 1'b0;
        nr <= '0;
        if (legal) begin
          for (int k = 0; k < 8; k++) if (k < int'(nk_in)) w[k] <= bus.key[255 - 32 * k -: 32];
          i <= {2'b00, nk_in};
          ph <= '0;
          nk <= nk_in;
          kl_q <= bus.key_len;
          rcon <= 8'h01;
          state <= ST_EXPAND;
        end else begin
          key_err <= 1'b1;
          state <= ST_IDLE;
        end
      end else if (state == ST_EXPAND) begin
        if (i == nw_of(kl_q)) begin
          keys_valid <= 1'b1;
          nr <= nr_of(kl_q);
          state <= ST_READY;
        end else begin
          w[i] <= w_new;
          i <= i + 6'd1;
          ph <= {1'b0, ph} == nk - 4'd1 ? 3'd0 : ph + 3'd1;
          if (ph == 3'd0) rcon <= xtime(rcon);
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: FIPS-197 key expansion vectors plus illegal-length, held-start and reset corner cases
module tb_aes_key_expand_seq;
  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    int           lat;
    logic [3:0]   nr;
    logic [127:0] rk0;
    logic [3:0]   mid_idx;
    logic [127:0] rk_mid;
    logic [127:0] rk_last;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  vec_t v [3];
  aes_key_expand_seq_if bif ();
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
  logic zeroize = 1'b0;
  aes_key_expand_seq #(.MAX_KEY_BITS(256)) dut (.clk(clk), .rst_n(rst_n), .zeroize(zeroize), .bus(bif));
`else
  aes_key_expand_seq #(.MAX_KEY_BITS(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_start(input logic [1:0] kl, input logic [255:0] key, output int lat);
    @(negedge clk);
    bif.key_len = kl;
    bif.key = key;
    bif.start_valid = 1'b1;
    @(negedge clk);
    bif.start_valid = 1'b0;
    lat = 0;
    while (!bif.keys_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic rd(input logic [3:0] idx, input string name, input logic [127:0] exp);
    bif.rk_rd_idx = idx;
    #1;
    chk(name, bif.rk_rd_data, exp);
  endtask
  initial begin
    int lat, bad;
    v[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef}, 41, 4'd10,
             128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605,
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    v[1] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffff_ffffffff}, 47, 4'd12,
             128'h8e73b0f7da0e6452c810f32b809079e5, 4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5,
             128'he98ba06f448c773c8ecc720401002202};
    v[2] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 53, 4'd14,
             128'h603deb1015ca71be2b73aef0857d7781, 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde,
             128'hfe4890d1e6188d0b046df344706c631e};
    bif.start_valid = 1'b0;
    bif.key_len = 2'd0;
    bif.key = '0;
    bif.rk_rd_idx = 4'd0;
    #3;
    chk("reset_start_ready", 128'(bif.start_ready), 128'd1);
    chk("reset_keys_valid", 128'(bif.keys_valid), 128'd0);
    chk("reset_key_err", 128'(bif.key_err), 128'd0);
    chk("reset_nr", 128'(bif.nr), 128'd0);
    chk("reset_rk_rd_data", bif.rk_rd_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      run_start(v[n].kl, v[n].key, lat);
      chk($sformatf("v%0d_latency", n), 128'(lat), 128'(v[n].lat));
      chk($sformatf("v%0d_nr", n), 128'(bif.nr), 128'(v[n].nr));
      rd(4'd0, $sformatf("v%0d_rk0", n), v[n].rk0);
      rd(v[n].mid_idx, $sformatf("v%0d_rk_mid", n), v[n].rk_mid);
      rd(v[n].nr, $sformatf("v%0d_rk_last", n), v[n].rk_last);
      rd(v[n].nr + 4'd1, $sformatf("v%0d_rk_over", n), 128'd0);
    end
    rd(4'd15, "rk_idx15", 128'd0);
    // illegal key_len while keys are loaded: one-cycle error, keys hidden
    @(negedge clk);
    bif.key_len = 2'd3;
    bif.start_valid = 1'b1;
    bif.rk_rd_idx = 4'd14;
    @(negedge clk);
    bif.start_valid = 1'b0;
    chk("ill_key_err", 128'(bif.key_err), 128'd1);
    chk("ill_keys_valid", 128'(bif.keys_valid), 128'd0);
    chk("ill_nr", 128'(bif.nr), 128'd0);
    chk("ill_rk_data", bif.rk_rd_data, 128'd0);
    chk("ill_start_ready", 128'(bif.start_ready), 128'd1);
    @(negedge clk);
    chk("ill_key_err_pulse", 128'(bif.key_err), 128'd0);
    // start held through an expansion: blocked until READY, then the second key wins
    @(negedge clk);
    bif.key_len = 2'd0;
    bif.key = v[0].key;
    bif.start_valid = 1'b1;
    @(negedge clk);
    bif.key_len = 2'd2;
    bif.key = v[2].key;
    bad = 0;
    lat = 0;
    while (!bif.keys_valid && lat < 200) begin
      if (bif.start_ready) bad++;
      @(negedge clk);
      lat++;
    end
    chk("held_ready_low", 128'(bad), 128'd0);
    chk("held_first_lat", 128'(lat), 128'd41);
    rd(4'd10, "held_first_rk", v[0].rk_last);
    @(negedge clk);
    bif.start_valid = 1'b0;
    chk("held_kv_drop", 128'(bif.keys_valid), 128'd0);
    lat = 0;
    while (!bif.keys_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("held_second_lat", 128'(lat), 128'd53);
    chk("held_second_nr", 128'(bif.nr), 128'd14);
    rd(4'd14, "held_second_rk", v[2].rk_last);
    // asynchronous reset in the middle of an AES-256 expansion
    @(negedge clk);
    bif.key_len = 2'd2;
    bif.key = v[2].key;
    bif.start_valid = 1'b1;
    @(negedge clk);
    bif.start_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_ready_low", 128'(bif.start_ready), 128'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_start_ready", 128'(bif.start_ready), 128'd1);
    chk("rst_keys_valid", 128'(bif.keys_valid), 128'd0);
    chk("rst_nr", 128'(bif.nr), 128'd0);
    bif.rk_rd_idx = 4'd0;
    #1;
    chk("rst_rk_data", bif.rk_rd_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_keys_valid", 128'(bif.keys_valid), 128'd0);
    run_start(v[0].kl, v[0].key, lat);
    chk("post_rst_lat", 128'(lat), 128'd41);
    rd(4'd10, "post_rst_rk", v[0].rk_last);
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    @(negedge clk);
    zeroize = 1'b1;
    #1;
    chk("zero_start_ready", 128'(bif.start_ready), 128'd0);
    @(negedge clk);
    zeroize = 1'b0;
    chk("zero_keys_valid", 128'(bif.keys_valid), 128'd0);
    chk("zero_nr", 128'(bif.nr), 128'd0);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      bif.rk_rd_idx = 4'(k);
      #1;
      if (bif.rk_rd_data !== 128'd0) bad++;
    end
    chk("zero_rk_all", 128'(bad), 128'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
